// File: rtl/rej_sample_collector.sv
// rej_sample_collector: compacts accepted sampler lanes into a buffer and writes coefficients to memory
module rej_sample_collector #(
  parameter int NUM_LANES    = 5,
  parameter int SAMPLE_W     = 23,
  parameter int NUM_COEFF    = 256,
  parameter int COEFF_PER_WR = 4,
  parameter int BUF_DEPTH    = NUM_LANES + COEFF_PER_WR - 1,
  localparam int AW = $clog2(NUM_COEFF / COEFF_PER_WR),
  localparam int CW = $clog2(BUF_DEPTH + 1),
  localparam int NW = $clog2(NUM_COEFF + 1),
  localparam int IW = $clog2(BUF_DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             zeroize,
  input  logic                             start_i,
  input  logic [NUM_LANES-1:0]             valid_i,
  input  logic [NUM_LANES*SAMPLE_W-1:0]    data_i,
  output logic                             hold_o,
  output logic                             mem_we_o,
  output logic [AW-1:0]                    mem_addr_o,
  output logic [COEFF_PER_WR*SAMPLE_W-1:0] mem_wdata_o,
  output logic                             done_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [SAMPLE_W-1:0] buf_q [BUF_DEPTH];
  logic [SAMPLE_W-1:0] buf_nx [BUF_DEPTH];
  logic [CW-1:0] buf_cnt, buf_cnt_nx;
  logic [NW-1:0] coeff_cnt, coeff_cnt_nx;
  logic [AW-1:0] wr_cnt;
  logic [COEFF_PER_WR*SAMPLE_W-1:0] wdata_nx;
  logic drain, last_wr, accept;
  assign drain   = state == RUN && buf_cnt >= CW'(COEFF_PER_WR);
  assign last_wr = drain && wr_cnt == AW'(NUM_COEFF / COEFF_PER_WR - 1);
  assign hold_o  = state != RUN || (buf_cnt - (drain ? CW'(COEFF_PER_WR) : CW'(0))) > CW'(BUF_DEPTH - NUM_LANES);
  assign accept  = state == RUN && !hold_o;
  // shift out the drained word, then append valid lanes lowest first, stopping at the coefficient limit
  always_comb begin
    int pos;
    int cnt;
    buf_nx = buf_q;
    wdata_nx = '0;
    for (int j = 0; j < COEFF_PER_WR; j++) wdata_nx[j*SAMPLE_W +: SAMPLE_W] = buf_q[j];
    if (drain)
      for (int i = 0; i < BUF_DEPTH - COEFF_PER_WR; i++) buf_nx[i] = buf_q[i+COEFF_PER_WR];
    pos = drain ? int'(buf_cnt) - COEFF_PER_WR : int'(buf_cnt);
    cnt = int'(coeff_cnt);
    if (accept)
      for (int k = 0; k < NUM_LANES; k++)
        if (valid_i[k] && cnt < NUM_COEFF) begin
          buf_nx[IW'(pos)] = data_i[k*SAMPLE_W +: SAMPLE_W];
          pos++;
          cnt++;
        end
    buf_cnt_nx = last_wr ? CW'(0) : CW'(pos);
    coeff_cnt_nx = NW'(cnt);
  end
  // polynomial sequencing: IDLE -> RUN -> DONE -> IDLE
  always_comb begin
    state_nx = state;
    if (state == IDLE && start_i) state_nx = RUN;
    else if (state == RUN && last_wr) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end
  // state, buffer, counters and registered memory write port
  always_ff @(posedge clk) begin
    buf_q <= buf_nx;
    if (rst || zeroize) begin
      state       <= IDLE;
      buf_cnt     <= '0;
      coeff_cnt   <= '0;
      wr_cnt      <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      done_o      <= 1'b0;
    end else begin
      state     <= state_nx;
      buf_cnt   <= state == RUN ? buf_cnt_nx : CW'(0);
      coeff_cnt <= state == IDLE ? NW'(0) : coeff_cnt_nx;
      wr_cnt    <= state == IDLE ? AW'(0) : wr_cnt + AW'(drain);
      mem_we_o  <= drain;
      done_o    <= state == DONE;
      if (drain) begin
        mem_addr_o  <= wr_cnt;
        mem_wdata_o <= wdata_nx;
      end
    end
  end
endmodule

// File: tb/tb_rej_sample_collector.sv
// tb_rej_sample_collector: directed checks of lane compaction, write sequencing, backpressure and reset
module tb_rej_sample_collector;
  localparam int L = 5, W = 23;
  logic clk = 0, rst = 1, zeroize = 0, start_i = 0;
  logic [L-1:0] valid_i = '0;
  logic [L*W-1:0] data_i = '0;
  logic hold_o, mem_we_o, done_o;
  logic [5:0] mem_addr_o;
  logic [4*W-1:0] mem_wdata_o, last_wdata, first_wdata;
  logic [5:0] last_addr, first_addr;
  int vectors = 0, errs = 0, writes = 0, dones = 0, exp_addr = 0, pushed = 0, holds = 0;
  logic [W-1:0] exp_q [$];
  bit acc;
  rej_sample_collector dut (
    .clk(clk), .rst(rst), .zeroize(zeroize), .start_i(start_i), .valid_i(valid_i), .data_i(data_i),
    .hold_o(hold_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .done_o(done_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic [L-1:0] v, input logic [L*W-1:0] d, input logic st, output bit a);
    valid_i = v;
    data_i = d;
    start_i = st;
    @(negedge clk);
    a = !hold_o;
    if (a)
      for (int k = 0; k < L; k++)
        if (v[k] && pushed < 256) begin
          exp_q.push_back(d[k*W +: W]);
          pushed++;
        end
    @(posedge clk);
    #1;
  endtask
  task automatic begin_poly();
    exp_q.delete();
    pushed = 0;
    exp_addr = 0;
    writes = 0;
    step('0, '0, 1'b1, acc);
  endtask
  task automatic feed(input int mode, input int stop_wr, input int budget);
    logic [L-1:0] pats [12] = '{5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1B, 5'h0E, 5'h1F, 5'h15, 5'h1F, 5'h1F, 5'h1F, 5'h00};
    logic [L-1:0] v;
    logic [L*W-1:0] d;
    int n = 0, p = 0, c = 0, d0 = dones;
    bit a;
    v = 5'h1F;
    for (int k = 0; k < L; k++) d[k*W +: W] = W'(k);
    while (dones == d0 && writes < stop_wr && c < budget) begin
      step(v, d, 1'b0, a);
      c++;
      if (!a) holds++;
      else if (mode == 0) begin
        n += L;
        for (int k = 0; k < L; k++) d[k*W +: W] = W'(n + k);
      end else begin
        p = (p + 1) % 12;
        v = pats[p];
        for (int k = 0; k < L; k++) d[k*W +: W] = W'($urandom_range(0, 8380416));
      end
    end
    chk("feed_timeout", c < budget, 1);
  endtask
  always @(negedge clk) begin
    if (mem_we_o) begin
      if (exp_q.size() < 4) chk("wr_spurious", mem_we_o, 0);
      else begin
        chk("wr_addr", mem_addr_o, exp_addr);
        for (int j = 0; j < 4; j++) chk("wr_coeff", mem_wdata_o[j*W +: W], exp_q.pop_front());
        exp_addr++;
      end
      if (writes == 0) begin
        first_wdata = mem_wdata_o;
        first_addr = mem_addr_o;
      end
      writes++;
      last_wdata = mem_wdata_o;
      last_addr = mem_addr_o;
    end
    if (done_o) begin
      dones++;
      chk("done_after_last_wr", writes, 64);
    end
  end
  initial begin
    step('0, '0, 1'b0, acc);
    step('0, '0, 1'b0, acc);
    chk("rst_we", mem_we_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_hold", hold_o, 1);
    chk("rst_addr", mem_addr_o, 0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      step('0, '0, 1'b0, acc);
      chk("idle_hold", hold_o, 1);
    end
    begin_poly();
    chk("run_hold", hold_o, 0);
    step(5'b10100, {23'h22, 23'h0, 23'h11, 46'h0}, 1'b0, acc);
    step(5'b00001, {92'h0, 23'h33}, 1'b0, acc);
    step(5'b01000, {23'h0, 23'h44, 69'h0}, 1'b0, acc);
    for (int i = 0; i < 4; i++) step('0, '0, 1'b0, acc);
    chk("order_writes", writes, 1);
    chk("order_addr", last_addr, 0);
    chk("order_wdata", last_wdata, {23'h44, 23'h33, 23'h22, 23'h11});
    zeroize = 1;
    step('0, '0, 1'b0, acc);
    zeroize = 0;
    chk("zeroize_hold", hold_o, 1);
    dones = 0;
    holds = 0;
    begin_poly();
    feed(0, 1000, 1000);
    for (int i = 0; i < 3; i++) step(5'h1F, '1, 1'b0, acc);
    chk("full_writes", writes, 64);
    chk("full_dones", dones, 1);
    chk("full_hold_seen", holds > 0, 1);
    chk("full_last_addr", last_addr, 63);
    chk("full_last_wdata", last_wdata, {23'd255, 23'd254, 23'd253, 23'd252});
    chk("full_q_empty", exp_q.size(), 0);
    chk("full_idle_hold", hold_o, 1);
    holds = 0;
    begin_poly();
    feed(1, 1000, 1000);
    for (int i = 0; i < 3; i++) step('0, '0, 1'b0, acc);
    chk("bp_writes", writes, 64);
    chk("bp_dones", dones, 2);
    chk("bp_hold_seen", holds > 0, 1);
    chk("bp_q_empty", exp_q.size(), 0);
    begin_poly();
    for (int i = 0; i < 100; i++) step('0, '1, i % 10 == 3, acc);
    chk("idle_writes", writes, 0);
    chk("idle_still_run", hold_o, 0);
    chk("idle_dones", dones, 2);
    feed(0, 10, 500);
    rst = 1;
    step('0, '0, 1'b0, acc);
    rst = 0;
    chk("midrst_hold", hold_o, 1);
    chk("midrst_we", mem_we_o, 0);
    step('0, '0, 1'b0, acc);
    chk("midrst_no_done", dones, 2);
    begin_poly();
    feed(0, 1000, 1000);
    for (int i = 0; i < 3; i++) step('0, '0, 1'b0, acc);
    chk("restart_first_addr", first_addr, 0);
    chk("restart_first_wdata", first_wdata, {23'd3, 23'd2, 23'd1, 23'd0});
    chk("restart_writes", writes, 64);
    chk("restart_dones", dones, 3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
